control_fsm: RTL
================

# control_fsm

Multicycle control unit for the 16-bit accumulator processor: drives every control input of integration stage 1 (PCWrite, Jump, Branch, IorD, DataSrc, MemWrite, MemRead, IRWrite) plus accumulator/ALU selects. It consumes the datapath's IROut, ShouldBranchIn-equivalent and Overflow. It sequences FETCH, DECODE and per-class execute states, and is the initiator side of the interface the stage-1 datapath responds to.

## Interface
- No parameters; state encoding is fixed (4-bit, listed under Operation).
- CLK  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low (0 = reset)
- IR  input  16  instruction register contents; opcode = IR[15:12]
- ShouldBranch  input  1  datapath compare result, consumed by datapath PC gate; controller only observes it for the Taken debug output
- Overflow  input  1  ALU overflow, sampled in ALU_EX
- PCWrite, Jump, MemWrite, MemRead, IRWrite, AccWrite  output  1 each  datapath strobes
- Branch  output  2  00 none, 01 take if ShouldBranch=1, 10 take if ShouldBranch=0, 11 unused
- IorD  output  2  memory address: 0 PC, 1 ALUOut, 2 Imm, 3 SP
- DataSrc  output  2  memory write data: 0 Acc, 1 PC, 2 Inputio, 3 ALUOut
- AccSrc  output  2  accumulator write data: 0 ALUOut, 1 MDR, 2 Inputio
- ALUSrcA  output  1  0 PC, 1 Acc;  ALUSrcB  output  2  0 MDR, 1 Imm, 2 constant 2
- ALUOp  output  3  000 add, 001 and, 010 or, 011 sub
- State  output  4  current state (debug);  Halted  output  1  in HALT;  Illegal  output  1  sticky, undefined opcode seen

## Operation
- Moore outputs decoded from state only; unlisted outputs are 0 in every state.
- States: IDLE=0, FETCH=1, DECODE=2, ALU_EX=3, ACC_WB=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BR=8, JMP=9, IO_WB=10, HALT=15.
- IDLE: all outputs 0; -> FETCH unconditionally.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=2, ALUOp=000, PCWrite=1 (PC <- PC+2). -> DECODE.
- DECODE: no strobes; dispatch on IR[15:12]:
  - 0x0 ADDI/0x1 ANDI/0x2 ORI/0x3 SUBI -> ALU_EX
  - 0x4 LW -> MEM_RD; 0x5 SW -> MEM_WR; 0x6 BEQ, 0x7 BNE -> BR; 0x8 J -> JMP; 0x9 IN -> IO_WB
  - 0xF HALT -> HALT; 0xA-0xE -> HALT with Illegal set.
- ALU_EX: ALUSrcA=1, ALUSrcB=1, ALUOp = IR[13:12] (0x0->000, 0x1->001, 0x2->010, 0x3->011). Overflow=1 -> HALT (no writeback); else -> ACC_WB.
- ACC_WB: AccWrite=1, AccSrc=0. -> FETCH.
- MEM_RD: MemRead=1, IorD=2. -> MEM_WB. MEM_WB: AccWrite=1, AccSrc=1. -> FETCH.
- MEM_WR: MemWrite=1, IorD=2, DataSrc=0. -> FETCH.
- BR: ALUSrcA=1, ALUSrcB=1, ALUOp=011, Branch=01 (BEQ) or 10 (BNE), PCWrite=0; datapath writes PC <- Imm when condition holds. -> FETCH.
- JMP: Jump=1, PCWrite=1. -> FETCH.
- IO_WB: AccWrite=1, AccSrc=2. -> FETCH.
- HALT: Halted=1, all strobes 0; remains until Reset.
- MemRead and MemWrite never both 1; at most one of PCWrite/Branch!=00 per state.

## Timing
- Reset assertion: state=IDLE and all outputs 0 (Illegal cleared) immediately, no clock needed; applies mid-instruction, including a pending MEM_WR (write suppressed).
- Reset release: first rising edge -> FETCH; second -> DECODE.
- Memory is synchronous single-cycle: IR valid in DECODE after FETCH edge; MDR valid in MEM_WB.
- Cycles per instruction: ALU-imm 4, LW 4, SW 3, BEQ/BNE 3, J 3, IN 3; HALT/illegal reach HALT at DECODE+1.
- Overflow sampled only on the ALU_EX->next edge; ignored in all other states.
- IR must be stable from the FETCH edge through end of instruction; controller never reasserts IRWrite outside FETCH.

## Test plan
- Reset held 0 for 2 cycles, release: State 0 -> 1 -> 2; during reset every output 0; FETCH shows MemRead=1, IRWrite=1, PCWrite=1, IorD=0, ALUSrcB=2.
- IR=0x0005 (ADDI 5), Overflow=0: states 1,2,3,4,1; ALU_EX ALUOp=000, ALUSrcB=1; ACC_WB AccWrite=1, AccSrc=0; repeat with Overflow=1 -> State 15, Halted=1, AccWrite never 1.
- IR=0x4010 then 0x5010: LW shows MEM_RD IorD=2 MemRead=1, MEM_WB AccSrc=1; SW shows single MEM_WR cycle, MemWrite=1, DataSrc=0, then FETCH.
- IR=0x6020 and 0x7020 with ShouldBranch toggled: BR cycle Branch=01 / 10, PCWrite=0, ALUOp=011; IR=0x8040: JMP Jump=1 PCWrite=1; each returns to FETCH in 3 cycles.
- IR=0xB000: DECODE -> HALT, Illegal=1, Halted=1, stays 10+ cycles; Reset pulse 0 clears Illegal and restarts at IDLE.
- Reset asserted asynchronously mid-MEM_WR (between edges): MemWrite drops to 0 the same instant, State=0.

Source files
------------

// File: rtl/control_fsm.sv
// Multicycle control unit for the 16-bit accumulator processor.
// Moore-style strobes are decoded from the current state, and a sticky flag records any undefined opcode.
module control_fsm (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] IR,
  input  logic        ShouldBranch,
  input  logic        Overflow,
  output logic        PCWrite,
  output logic        Jump,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        IRWrite,
  output logic        AccWrite,
  output logic [1:0]  Branch,
  output logic [1:0]  IorD,
  output logic [1:0]  DataSrc,
  output logic [1:0]  AccSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic [3:0]  State,
  output logic        Halted,
  output logic        Illegal,
  output logic        Taken
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_ALU_EX = 4'd3,
    ST_ACC_WB = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WB = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_BR     = 4'd8,
    ST_JMP    = 4'd9,
    ST_IO_WB  = 4'd10,
    ST_HALT   = 4'd15
  } state_t;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[15:12];
  assign unused_ir = ^IR[11:0];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          4'h0, 4'h1, 4'h2, 4'h3: state_d = ST_ALU_EX;
          4'h4:                   state_d = ST_MEM_RD;
          4'h5:                   state_d = ST_MEM_WR;
          4'h6, 4'h7:             state_d = ST_BR;
          4'h8:                   state_d = ST_JMP;
          4'h9:                   state_d = ST_IO_WB;
          4'hF:                   state_d = ST_HALT;
          default: begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Overflow aborts the instruction before the accumulator is touched.
      ST_ALU_EX: state_d = Overflow ? ST_HALT : ST_ACC_WB;
      ST_ACC_WB: state_d = ST_FETCH;
      ST_MEM_RD: state_d = ST_MEM_WB;
      ST_MEM_WB: state_d = ST_FETCH;
      ST_MEM_WR: state_d = ST_FETCH;
      ST_BR:     state_d = ST_FETCH;
      ST_JMP:    state_d = ST_FETCH;
      ST_IO_WB:  state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    Jump     = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    IRWrite  = 1'b0;
    AccWrite = 1'b0;
    Branch   = 2'b00;
    IorD     = 2'd0;
    DataSrc  = 2'd0;
    AccSrc   = 2'd0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    ALUOp    = 3'b000;
    Halted   = 1'b0;
    Taken    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'd2;
      end
      ST_ALU_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd1;
        ALUOp   = {1'b0, IR[13:12]};
      end
      ST_ACC_WB: AccWrite = 1'b1;
      ST_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 2'd2;
      end
      ST_MEM_WB: begin
        AccWrite = 1'b1;
        AccSrc   = 2'd1;
      end
      ST_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 2'd2;
      end
      // IR[12] separates BNE (0x7) from BEQ (0x6).
      ST_BR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd1;
        ALUOp   = 3'b011;
        Branch  = IR[12] ? 2'b10 : 2'b01;
        Taken   = IR[12] ? ~ShouldBranch : ShouldBranch;
      end
      ST_JMP: begin
        Jump    = 1'b1;
        PCWrite = 1'b1;
      end
      ST_IO_WB: begin
        AccWrite = 1'b1;
        AccSrc   = 2'd2;
      end
      ST_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  assign State   = state_q;
  assign Illegal = illegal_q;

endmodule
